// File: rtl/alu_pkg.sv
// Shared op encodings, field positions and state type for the sequenced ALU.
package alu_pkg;

  typedef enum logic [4:0] {
    OP_ADD    = 5'b00000,
    OP_SUB    = 5'b01000,
    OP_SLL    = 5'b00001,
    OP_SLT    = 5'b00010,
    OP_SLTU   = 5'b00011,
    OP_XOR    = 5'b00100,
    OP_SRL    = 5'b00101,
    OP_SRA    = 5'b01101,
    OP_OR     = 5'b00110,
    OP_AND    = 5'b00111,
    OP_LUI    = 5'b01111,
    OP_MUL    = 5'b10000,
    OP_MULH   = 5'b10001,
    OP_MULHSU = 5'b10010,
    OP_MULHU  = 5'b10011,
    OP_DIV    = 5'b10100,
    OP_DIVU   = 5'b10101,
    OP_REM    = 5'b10110,
    OP_REMU   = 5'b10111
  } alu_op_e;

  localparam int M_SEL_BIT = 4;
  localparam int F3_LSB    = 0;
  localparam int F3_MSB    = 2;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    FIX  = 2'd2
  } state_e;

endpackage

// File: rtl/muldiv_iter.sv
// Iterative 1-bit/cycle multiply (shift-add) and restoring divide on operand magnitudes,
// with sign fix-up applied to the final step's values.
module muldiv_iter
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             start,
  input  logic [2:0]       funct3,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  output logic             fix_next,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam int CW = $clog2(WIDTH) + 1;

  logic [WIDTH-1:0]   hi_q, lo_q, mcand_q, hi_d, lo_d, a_mag, b_mag, quo, rem;
  logic [CW-1:0]      cnt_q;
  logic [2:0]         f3_q;
  logic               qneg_q, rneg_q, a_signed, b_signed, a_neg, b_neg;
  logic [WIDTH:0]     trial, sum;
  logic [2*WIDTH-1:0] prod;

  always_comb begin
    a_signed = funct3[2] ? !funct3[0] : ((funct3 == F3_MULH) || (funct3 == F3_MULHSU));
    b_signed = funct3[2] ? !funct3[0] : (funct3 == F3_MULH);
    a_neg    = a_signed && operand_a[WIDTH-1];
    b_neg    = b_signed && operand_b[WIDTH-1];
    a_mag    = a_neg ? -operand_a : operand_a;
    b_mag    = b_neg ? -operand_b : operand_b;
  end

  // hi holds the running upper product / partial remainder, lo the multiplier / quotient
  assign trial = {hi_q, lo_q[WIDTH-1]} - {1'b0, mcand_q};
  assign sum   = {1'b0, hi_q} + ({1'b0, mcand_q} & {(WIDTH+1){lo_q[0]}});

  always_comb begin
    hi_d = hi_q;
    lo_d = lo_q;
    if (f3_q[2]) begin
      if (!trial[WIDTH]) begin
        hi_d = trial[WIDTH-1:0];
        lo_d = {lo_q[WIDTH-2:0], 1'b1};
      end else begin
        hi_d = {hi_q[WIDTH-2:0], lo_q[WIDTH-1]};
        lo_d = {lo_q[WIDTH-2:0], 1'b0};
      end
    end else begin
      hi_d = sum[WIDTH:1];
      lo_d = {sum[0], lo_q[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi_q    <= '0;
      lo_q    <= '0;
      mcand_q <= '0;
      cnt_q   <= '0;
      f3_q    <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
    end else if (flush) begin
      cnt_q <= '0;
    end else if (start) begin
      hi_q    <= '0;
      lo_q    <= funct3[2] ? a_mag : b_mag;
      mcand_q <= funct3[2] ? b_mag : a_mag;
      f3_q    <= funct3;
      qneg_q  <= a_neg ^ b_neg;
      rneg_q  <= a_neg;
      cnt_q   <= CW'(WIDTH);
    end else if (cnt_q != '0) begin
      hi_q  <= hi_d;
      lo_q  <= lo_d;
      cnt_q <= cnt_q - CW'(1);
    end
  end

  assign fix_next = (cnt_q == CW'(2));
  assign done     = (cnt_q == CW'(1));

  // Result is taken from the last step's next-state values so FIX needs no extra edge
  always_comb begin
    prod   = qneg_q ? -{hi_d, lo_d} : {hi_d, lo_d};
    quo    = qneg_q ? -lo_d : lo_d;
    rem    = rneg_q ? -hi_d : hi_d;
    result = prod[2*WIDTH-1:WIDTH];
    if (f3_q[2])
      result = f3_q[1] ? rem : quo;
    else if (f3_q[1:0] == 2'b00)
      result = prod[WIDTH-1:0];
  end

endmodule

// File: rtl/alu_seq.sv
// Handshaked ALU: single-cycle RV32I ops with registered result, iterative RV32M mul/div.
//   state | meaning
//   IDLE  | accepting requests; base ops and div special cases complete here
//   ITER  | mul/div stepping one bit per edge
//   FIX   | final step, sign fix-up, result registered
module alu_seq
  import alu_pkg::*;
#(
  parameter  int WIDTH = 32,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_flush,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [4:0]       i_alu_op,
  input  logic [WIDTH-1:0] i_operand_a,
  input  logic [WIDTH-1:0] i_operand_b,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_alu_data
);

  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  state_e           state_q, state_d;
  logic [2:0]       funct3;
  logic [SHW-1:0]   shamt;
  logic             op_m, accept, div_zero, div_ovf, special, mdu_start, mdu_fix_next, mdu_done;
  logic [WIDTH-1:0] base_res, special_res, quick_res, mdu_res;

  assign op_m      = i_alu_op[M_SEL_BIT];
  assign funct3    = i_alu_op[F3_MSB:F3_LSB];
  assign shamt     = i_operand_b[SHW-1:0];
  assign o_ready   = (state_q == IDLE) && (!o_valid || i_ready);
  assign accept    = i_valid && o_ready && !i_flush;
  assign div_zero  = (i_operand_b == '0);
  assign div_ovf   = !funct3[0] && (i_operand_a == MOST_NEG) && (i_operand_b == '1);
  assign special   = op_m && funct3[2] && (div_zero || div_ovf);
  assign mdu_start = accept && op_m && !special;
  assign quick_res = op_m ? special_res : base_res;

  always_comb begin
    base_res = '0;
    case (alu_op_e'(i_alu_op))
      OP_ADD:  base_res = i_operand_a + i_operand_b;
      OP_SUB:  base_res = i_operand_a - i_operand_b;
      OP_SLL:  base_res = i_operand_a << shamt;
      OP_SLT:  base_res = WIDTH'($signed(i_operand_a) < $signed(i_operand_b));
      OP_SLTU: base_res = WIDTH'(i_operand_a < i_operand_b);
      OP_XOR:  base_res = i_operand_a ^ i_operand_b;
      OP_SRL:  base_res = i_operand_a >> shamt;
      OP_SRA:  base_res = $signed(i_operand_a) >>> shamt;
      OP_OR:   base_res = i_operand_a | i_operand_b;
      OP_AND:  base_res = i_operand_a & i_operand_b;
      OP_LUI:  base_res = i_operand_b;
      default: base_res = '0;
    endcase
  end

  // funct3[1] separates remainder from quotient
  always_comb begin
    special_res = '0;
    if (div_zero)
      special_res = funct3[1] ? i_operand_a : '1;
    else
      special_res = funct3[1] ? '0 : i_operand_a;
  end

  muldiv_iter #(.WIDTH(WIDTH)) u_muldiv (
    .clk       (i_clk),
    .rst_n     (i_rst_n),
    .flush     (i_flush),
    .start     (mdu_start),
    .funct3    (funct3),
    .operand_a (i_operand_a),
    .operand_b (i_operand_b),
    .fix_next  (mdu_fix_next),
    .done      (mdu_done),
    .result    (mdu_res)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (i_flush) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (mdu_start) state_d = ITER;
        ITER:    if (mdu_fix_next) state_d = FIX;
        FIX:     if (mdu_done) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_valid    <= 1'b0;
      o_alu_data <= '0;
    end else if (i_flush) begin
      o_valid <= 1'b0;
    end else if (accept && !mdu_start) begin
      o_valid    <= 1'b1;
      o_alu_data <= quick_res;
    end else if ((state_q == FIX) && mdu_done) begin
      o_valid    <= 1'b1;
      o_alu_data <= mdu_res;
    end else if (i_ready) begin
      o_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq: vector table plus reference-model random mul/div through a scoreboard,
// then hand sequences for back-pressure, flush and asynchronous reset.
module tb_alu_seq;
  import alu_pkg::*;

  localparam int W = 32;

  logic         i_clk = 1'b0;
  logic         i_rst_n = 1'b0;
  logic         i_flush = 1'b0;
  logic         i_valid = 1'b0;
  logic         i_ready = 1'b1;
  logic [4:0]   i_alu_op = '0;
  logic [W-1:0] i_operand_a = '0;
  logic [W-1:0] i_operand_b = '0;
  logic         o_ready, o_valid;
  logic [W-1:0] o_alu_data;

  alu_seq #(.WIDTH(W)) dut (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_flush     (i_flush),
    .i_valid     (i_valid),
    .o_ready     (o_ready),
    .i_alu_op    (i_alu_op),
    .i_operand_a (i_operand_a),
    .i_operand_b (i_operand_b),
    .o_valid     (o_valid),
    .i_ready     (i_ready),
    .o_alu_data  (o_alu_data)
  );

  always #5 i_clk = ~i_clk;

  int cyc = 0;
  always @(posedge i_clk) cyc <= cyc + 1;

  typedef struct {
    logic [4:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  typedef struct {
    logic [31:0] exp;
    int          due;
  } sb_t;

  vec_t tbl[$];
  sb_t  sb[$];
  bit   seen = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", nm, act, req, cyc);
    end
  endfunction

  function automatic void add(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                              input logic [31:0] exp, input int lat);
    vec_t v;
    v.op = op; v.a = a; v.b = b; v.exp = exp; v.lat = lat;
    tbl.push_back(v);
  endfunction

  function automatic logic [31:0] ref_m(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    longint      sa = longint'($signed(a));
    longint      sbv = longint'($signed(b));
    longint      ub = longint'({32'b0, b});
    logic [63:0] p;
    logic        ovf;
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    p = '0;
    case (f3)
      3'd0: begin p = sa * sbv; return p[31:0]; end
      3'd1: begin p = sa * sbv; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (ovf) return a;
        p = sa / sbv; return p[31:0];
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (ovf) return 32'h0;
        p = sa % sbv; return p[31:0];
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  // Scoreboard: latency and data checked at first sighting, popped on consume
  always @(negedge i_clk) begin
    if (i_rst_n && o_valid) begin
      if (sb.size() == 0) begin
        chk("unexpected_valid", {31'b0, o_valid}, 32'd0);
      end else begin
        if (!seen) begin
          chk("latency", 32'(cyc), 32'(sb[0].due));
          chk("data", o_alu_data, sb[0].exp);
          seen = 1'b1;
        end
        if (i_ready) begin
          void'(sb.pop_front());
          seen = 1'b0;
        end
      end
    end
  end

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  // Called just after a rising edge; returns just after the accepting edge
  task automatic send(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] exp, input int lat, output int stall);
    sb_t e;
    stall = 0;
    i_valid = 1'b1;
    i_alu_op = op;
    i_operand_a = a;
    i_operand_b = b;
    @(negedge i_clk);
    while (!o_ready && stall < 100) begin
      @(negedge i_clk);
      stall++;
    end
    if (!o_ready) begin
      chk("send_timeout", {31'b0, o_ready}, 32'd1);
      tick();
    end else begin
      tick();
      e.exp = exp;
      e.due = cyc + lat - 1;
      sb.push_back(e);
    end
    i_valid = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got time %0t, expected end before 500000", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int stall, prev_lat, bad;
    logic [2:0] f3;
    logic [31:0] ra, rb;
    logic special;

    add(OP_ADD,  32'd10,         32'd20,         32'h0000_001E, 1);
    add(OP_SUB,  32'd10,         32'd20,         32'hFFFF_FFF6, 1);
    add(OP_SRA,  32'h8000_0000,  32'd1,          32'hC000_0000, 1);
    add(OP_SLTU, 32'd1,          32'hFFFF_FFFF,  32'd1,         1);
    add(OP_SLT,  32'd1,          32'hFFFF_FFFF,  32'd0,         1);
    add(OP_SLL,  32'd1,          32'h0000_0021,  32'd2,         1);
    add(OP_SRL,  32'h8000_0000,  32'd4,          32'h0800_0000, 1);
    add(OP_XOR,  32'h0000_F0F0,  32'h0000_FF00,  32'h0000_0FF0, 1);
    add(OP_OR,   32'h0000_00F0,  32'h0000_000F,  32'h0000_00FF, 1);
    add(OP_AND,  32'h0000_00F0,  32'h0000_003C,  32'h0000_0030, 1);
    add(OP_LUI,  32'hDEAD_BEEF,  32'h1234_5000,  32'h1234_5000, 1);
    add(5'b01001, 32'h1234_5678, 32'h1111_1111,  32'd0,         1);
    add(OP_MULH, 32'hFFFF_FFFF,  32'd2,          32'hFFFF_FFFF, 33);
    add(OP_MULHU, 32'hFFFF_FFFF, 32'd2,          32'd1,         33);
    add(OP_MUL,  32'd7,          32'd6,          32'h0000_002A, 33);
    add(OP_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33);
    add(OP_MULH, 32'h8000_0000,  32'h8000_0000,  32'h4000_0000, 33);
    add(5'b11000, 32'd3,         32'd5,          32'd15,        33);
    add(OP_DIV,  32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD, 33);
    add(OP_REM,  32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF, 33);
    add(OP_DIVU, 32'd100,        32'd7,          32'd14,        33);
    add(OP_REMU, 32'd100,        32'd7,          32'd2,         33);
    add(OP_DIVU, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,         33);
    add(OP_DIV,  32'd5,          32'd0,          32'hFFFF_FFFF, 1);
    add(OP_REM,  32'd5,          32'd0,          32'd5,         1);
    add(OP_DIV,  32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000, 1);
    add(OP_REM,  32'h8000_0000,  32'hFFFF_FFFF,  32'd0,         1);
    add(OP_REMU, 32'd5,          32'd0,          32'd5,         1);

    repeat (3) @(posedge i_clk);
    @(negedge i_clk);
    chk("reset_valid", {31'b0, o_valid}, 32'd0);
    chk("reset_data",  o_alu_data,       32'd0);
    chk("reset_ready", {31'b0, o_ready}, 32'd1);
    i_rst_n = 1'b1;
    tick();

    // Table: o_ready must be back exactly when the previous op's result is out
    prev_lat = 1;
    for (int i = 0; i < tbl.size(); i++) begin
      send(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].exp, tbl[i].lat, stall);
      chk("stall", 32'(stall), 32'(prev_lat - 1));
      prev_lat = tbl[i].lat;
    end

    for (int i = 0; i < 12; i++) begin
      f3 = 3'($urandom_range(0, 7));
      ra = $urandom;
      rb = (f3[2] && $urandom_range(0, 1) == 1) ? 32'($urandom_range(1, 300)) : $urandom;
      if (i == 5) rb = 32'd0;
      special = f3[2] && ((rb == 0) || (!f3[0] && ra == 32'h8000_0000 && rb == 32'hFFFF_FFFF));
      send({1'b1, 1'($urandom_range(0, 1)), f3}, ra, rb, ref_m(f3, ra, rb), special ? 1 : 33, stall);
    end
    repeat (40) tick();

    // Back-pressure on a MUL result, then consume and accept on the same edge
    i_ready = 1'b0;
    send(OP_MUL, 32'd7, 32'd6, 32'h2A, 33, stall);
    chk("bp_stall", 32'(stall), 32'd0);
    bad = 0;
    for (int k = 0; k < 32; k++) begin
      @(negedge i_clk);
      if (o_ready || o_valid) bad++;
    end
    chk("busy_ready_low", 32'(bad), 32'd0);
    bad = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge i_clk);
      if (!o_valid || o_alu_data !== 32'h2A || o_ready) bad++;
    end
    chk("hold_stable", 32'(bad), 32'd0);
    @(posedge i_clk);
    #1;
    i_ready = 1'b1;
    send(OP_ADD, 32'd1, 32'd2, 32'd3, 1, stall);
    chk("consume_accept_stall", 32'(stall), 32'd0);
    repeat (5) tick();

    // Flush during cycle 10 of a DIV
    send(OP_DIV, 32'd100, 32'd7, 32'd14, 33, stall);
    repeat (9) tick();
    i_flush = 1'b1;
    tick();
    i_flush = 1'b0;
    sb.delete();
    seen = 1'b0;
    @(negedge i_clk);
    chk("flush_ready", {31'b0, o_ready}, 32'd1);
    chk("flush_valid", {31'b0, o_valid}, 32'd0);
    bad = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge i_clk);
      if (o_valid) bad++;
    end
    chk("flush_no_result", 32'(bad), 32'd0);

    // Flush wins over a same-cycle request
    @(posedge i_clk);
    #1;
    i_flush = 1'b1;
    i_valid = 1'b1;
    i_alu_op = OP_ADD;
    i_operand_a = 32'd5;
    i_operand_b = 32'd5;
    tick();
    i_flush = 1'b0;
    i_valid = 1'b0;
    bad = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge i_clk);
      if (o_valid) bad++;
    end
    chk("flush_priority", 32'(bad), 32'd0);

    // Asynchronous reset mid-ITER
    @(posedge i_clk);
    #1;
    send(OP_MUL, 32'd3, 32'd3, 32'd9, 33, stall);
    repeat (5) tick();
    #2;
    i_rst_n = 1'b0;
    #1;
    chk("rst_async_valid", {31'b0, o_valid}, 32'd0);
    chk("rst_async_data",  o_alu_data,       32'd0);
    chk("rst_async_ready", {31'b0, o_ready}, 32'd1);
    sb.delete();
    seen = 1'b0;
    @(negedge i_clk);
    i_rst_n = 1'b1;
    bad = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge i_clk);
      if (o_valid || !o_ready) bad++;
    end
    chk("rst_no_result", 32'(bad), 32'd0);

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, handshaked successor to the single-cycle ALU of the RV32I datapath.
- Base RV32I ops keep the single-cycle ALU encoding and return results with 1-cycle registered latency.
- Adds RV32M multiply/divide, computed iteratively at 1 bit per cycle.
- Sits between decode/issue and writeback; a stalling core uses o_ready/o_valid to hold the pipeline.

Parameters:
- WIDTH, 32, operand/result width; power of two, >= 8.
- SHW, $clog2(WIDTH), shift-amount bits; derived, do not override.

Ports:
- i_clk  in  1  clock; all state updates on the rising edge.
- i_rst_n  in  1  asynchronous, active-low reset.
- i_flush  in  1  synchronous abort of any in-flight or held operation.
- i_valid  in  1  request valid.
- o_ready  out  1  unit can accept a request this cycle.
- i_alu_op  in  5  operation code; encoding under Behaviour.
- i_operand_a  in  WIDTH  operand A (rs1 / dividend / multiplicand).
- i_operand_b  in  WIDTH  operand B (rs2 / imm / divisor / multiplier).
- o_valid  out  1  result valid.
- i_ready  in  1  consumer accepts result.
- o_alu_data  out  WIDTH  result.

Behaviour:
- Op encoding, bit4 = 0 (base): ADD 0000, SUB 1000, SLL 0001, SLT 0010, SLTU 0011, XOR 0100, SRL 0101, SRA 1101, OR 0110, AND 0111, LUI 1111 (passes B). Other base codes return 0.
- Op encoding, bit4 = 1: low 3 bits are RV32M funct3: MUL 000, MULH 001, MULHSU 010, MULHU 011, DIV 100, DIVU 101, REM 110, REMU 111. Bit3 is ignored.
- Shifts use B[SHW-1:0] only. SLT compares signed; SLTU compares unsigned. All arithmetic is modulo 2^WIDTH.
- Reset (async assert, sync release): state IDLE, o_valid=0, o_alu_data=0, counter=0. o_ready is high in IDLE.
- Accept: i_valid && o_ready at a rising edge (E0).
- o_ready = (state==IDLE) && (!o_valid || i_ready), combinational.
- Base ops, div-by-zero and signed overflow: result registered at E0; o_valid is high in the following cycle (latency 1).
- Back-to-back base ops at full throughput when i_ready=1.
- Mul/div states: IDLE -> ITER -> FIX -> IDLE.
  - At E0: latch the magnitudes of signed operands, latch the result sign, load counter=WIDTH.
  - ITER: one shift-add (mul) or restoring-subtract (div) step per edge, counter decrements each edge. Leave for FIX when counter reaches 1.
  - FIX: apply sign correction and select high/low half or quotient/remainder; register result; set o_valid.
  - Total latency is WIDTH+1 edges (33 at WIDTH=32). o_ready is low throughout.
- Division special cases:
  - Divide by zero: quotient = all ones; remainder = dividend. Applies to both signed and unsigned.
  - Signed overflow (DIV/REM with A = most negative value, B = -1): quotient = A, remainder = 0.
- Sign rules for MULHSU: A is signed, B is unsigned. REM takes the sign of the dividend.
- Output hold: while o_valid=1 and i_ready=0, o_alu_data and o_valid stay stable. The result is consumed at the edge where o_valid && i_ready.
- Same-edge events:
  - A new request can be accepted on the same edge as a consume.
  - A result consumed with no new request drops o_valid.
- i_flush at any edge: state=IDLE, o_valid=0, counter cleared. It takes priority over an accept in the same cycle (the request is dropped). o_ready is high the next cycle.
- Reset mid-ITER abandons the operation with no output.

Decomposition:
- Package alu_pkg:
  - alu_op_e enum with all 19 codes.
  - Localparams for bit4 = M-select, and for the funct3 subfield position.
  - Typedef for the state enum {IDLE, ITER, FIX}.
- Sub-module muldiv_iter: holds the iterative datapath (partial product/remainder registers, counter, sign fix-up). Its interface is start/done, which alu_seq sequences.
- Base-op logic stays combinational inside alu_seq, feeding the output register.

Test Plan:
- Base ops, i_ready held 1, back-to-back each cycle: ADD 10+20 -> 0x1E; SUB 10-20 -> 0xFFFFFFF6; SRA 0x80000000>>1 -> 0xC0000000; SLTU 1 vs 0xFFFFFFFF -> 1. Each result appears one cycle after its accept, o_ready stays 1.
- MULH 0xFFFFFFFF x 0x00000002 -> 0xFFFFFFFF. MULHU on the same operands -> 0x00000001. MUL 7x6 -> 0x2A. o_valid asserted exactly 33 cycles after accept; o_ready low throughout.
- DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2. Each at 33-cycle latency.
- DIV 5/0 -> 0xFFFFFFFF; REM 5/0 -> 5; DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM same operands -> 0. Each with latency 1.
- Back-pressure: hold i_ready=0 for 5 cycles after the MUL result -> o_valid/o_alu_data stable, o_ready=0. Raise i_ready with a new i_valid ADD in the same cycle -> consume and accept on the same edge.
- i_flush at cycle 10 of a DIV -> o_valid never rises, o_ready=1 the next cycle. Assert i_rst_n=0 mid-ITER -> o_valid=0 and o_alu_data=0 immediately (asynchronous).
